pulse_period_meter: RTL

- Receiving end of the periodic pulse train produced by the team's pulse generator.
- Measures the number of clock cycles between consecutive rising edges of `pulse_in`.
- Reports each measurement with a one-cycle `valid` strobe, and flags gaps longer than the counter can represent.
- Used to check tick rates, for example by looping the generator's output back to this block for self-test.

---
 rtl/pulse_period_meter_pkg.sv | 15 +
 rtl/pulse_period_meter_if.sv | 26 ++
 rtl/pulse_period_meter_rising_edge_detector.sv | 22 ++
 rtl/pulse_period_meter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/pulse_period_meter_pkg.sv
// Shared types and constants for the pulse period meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pulse_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COUNT    = 2'd1,
        S_OVERFLOW = 2'd2
    } pulse_meter_state_t;

    // Number of completed periods averaged when the averager is built in.
    localparam int AVG_DEPTH = 4;

endpackage

// File: rtl/pulse_period_meter_if.sv
// Measurement bus between a pulse source/observer and the period meter.
// Latency: n/a (wiring only).
// Backpressure: none; results are strobes the observer must sample.
// Optional avg_period signal present when PULSE_MEASURE_AVG_EN is defined.
interface pulse_period_meter_if #(
    parameter int N = 8
);
    logic         ena;
    logic         pulse_in;
    logic [N-1:0] period;
    logic         valid;
    logic         overflow;
`ifdef PULSE_MEASURE_AVG_EN
    logic [N-1:0] avg_period;

    modport master (output ena, output pulse_in,
                    input period, input valid, input overflow, input avg_period);
    modport slave  (input ena, input pulse_in,
                    output period, output valid, output overflow, output avg_period);
`else
    modport master (output ena, output pulse_in,
                    input period, input valid, input overflow);
    modport slave  (input ena, input pulse_in,
                    output period, output valid, output overflow);
`endif
endinterface

// File: rtl/pulse_period_meter_rising_edge_detector.sv
// Rising-edge detector for a clk-synchronous pulse train.
// Latency: rise is combinational from pulse_in; history register is 1 cycle.
// Backpressure: none; history updates every cycle regardless of enable.
module rising_edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic rise
);

    logic pulse_d;

    // Previous-cycle copy of the input; cleared by reset so a level already
    // high right after reset is seen as a rise.
    always_ff @(posedge clk) begin
        if (rst) pulse_d <= 1'b0;
        else     pulse_d <= pulse_in;
    end

    assign rise = pulse_in & ~pulse_d;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clock cycles between consecutive rising edges of pulse_in.
// Latency: rise sampled at edge t -> valid/period visible after edge t (1 cycle).
// Backpressure: none; valid is a single-cycle strobe. Macro PULSE_MEASURE_AVG_EN adds avg_period.
module pulse_period_meter
    import pulse_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pulse_period_meter_if.slave  bus
);

    localparam logic [N-1:0] CNT_MAX = '1;

    pulse_meter_state_t state, state_nxt;
    logic [N-1:0] counter, counter_nxt;
    logic [N-1:0] period_q, period_nxt;
    logic         valid_q, valid_nxt;
    logic         overflow_q, overflow_nxt;
    logic         rise;

    rising_edge_detector u_edge (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (bus.pulse_in),
        .rise     (rise)
    );

    // State, counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            counter    <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            counter    <= counter_nxt;
            period_q   <= period_nxt;
            valid_q    <= valid_nxt;
            overflow_q <= overflow_nxt;
        end
    end

    // Next-state logic; a rise always beats saturation in the same cycle.
    always_comb begin
        state_nxt    = state;
        counter_nxt  = counter;
        period_nxt   = period_q;
        valid_nxt    = 1'b0;
        overflow_nxt = overflow_q;
        if (!bus.ena) begin
            state_nxt    = S_IDLE;
            counter_nxt  = '0;
            overflow_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        counter_nxt = N'(1);
                        state_nxt   = S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (rise) begin
                        period_nxt  = counter;
                        valid_nxt   = 1'b1;
                        counter_nxt = N'(1);
                    end else if (counter == CNT_MAX) begin
                        state_nxt    = S_OVERFLOW;
                        overflow_nxt = 1'b1;
                    end else begin
                        counter_nxt = counter + N'(1);
                    end
                end
                S_OVERFLOW: begin
                    // Gap too long to measure: re-arm without reporting.
                    if (rise) begin
                        overflow_nxt = 1'b0;
                        counter_nxt  = N'(1);
                        state_nxt    = S_COUNT;
                    end
                end
                default: begin
                    state_nxt   = S_IDLE;
                    counter_nxt = '0;
                end
            endcase
        end
    end

    assign bus.period   = period_q;
    assign bus.valid    = valid_q;
    assign bus.overflow = overflow_q;

`ifdef PULSE_MEASURE_AVG_EN
    logic [N-1:0] hist [AVG_DEPTH];
    logic [N+1:0] hist_sum;

    // History of completed periods, shifted on the edge that raises valid;
    // only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < AVG_DEPTH; i++) hist[i] <= '0;
        end else if (valid_nxt) begin
            hist[0] <= period_nxt;
            for (int i = 1; i < AVG_DEPTH; i++) hist[i] <= hist[i-1];
        end
    end

    // Floor mean of the history: widened sum, then divide by the depth.
    always_comb begin
        hist_sum = '0;
        for (int i = 0; i < AVG_DEPTH; i++) hist_sum = hist_sum + {2'b00, hist[i]};
    end

    assign bus.avg_period = hist_sum[N+1:2];
`endif

endmodule
